// File: rtl/ssd_pkg.sv
// ssd_pkg -- shared definitions for the seven-segment scan driver.
//   NUM_DIGITS    : number of multiplexed digits
//   ANODE_ALL_OFF : active-low anode pattern with every digit dark
//   digit_idx_t   : 2-bit digit slot index
//   anode_for()   : active-low anode pattern for a slot, or all-off if not lit
package ssd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] ANODE_ALL_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  function automatic logic [3:0] anode_for(input digit_idx_t idx, input logic lit);
    return lit ? ~(4'b0001 << idx) : ANODE_ALL_OFF;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler -- free-running divider that marks the end of each digit slot.
// Parameters:
//   DIV  : clock cycles per slot (2..2^20)
// Ports:
//   clk  : input  clock
//   rst  : input  asynchronous active-high reset
//   tick : output one-cycle pulse while the count sits at DIV-1
module scan_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] count;

  assign tick = (count == CNT_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver -- time-multiplexed scan driver for a 4-digit common-anode
// seven-segment display. Digits and enables are snapshotted once per frame so
// a frame always shows one coherent value.
// Parameters:
//   REFRESH_DIV  : clock cycles per digit slot (2..2^20)
//   BLINK_FRAMES : full frames per blink phase (1..1023), used with SSD_BLINK_EN
// Ports:
//   clk             : input  clock
//   rst             : input  asynchronous active-high reset
//   digits[15:0]    : input  four hex nibbles, digit 0 in bits [3:0]
//   digit_en[3:0]   : input  per-digit enable, 0 blanks the digit
//   blink_mask[3:0] : input  digits that blink (only with SSD_BLINK_EN)
//   display_element : output nibble for the hex-to-segment decoder
//   anode_n[3:0]    : output active-low digit enables, at most one low
//   frame_start     : output one-cycle pulse when slot 0 is first presented
// Configuration macro:
//   SSD_BLINK_EN : when defined, masked digits go dark every other
//                  BLINK_FRAMES-frame phase; otherwise blink_mask is ignored.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  display_element,
  output logic [3:0]  anode_n,
  output logic        frame_start
);

  logic        tick;
  logic        wrap;
  digit_idx_t  idx;
  digit_idx_t  next_idx;
  logic [15:0] sh_digits;
  logic [3:0]  sh_en;
  logic [15:0] src_digits;
  logic [3:0]  src_en;
  logic        blank;
  logic        lit;

  scan_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign next_idx = idx + 2'd1;
  assign wrap     = tick && (idx == digit_idx_t'(NUM_DIGITS - 1));

  // On the wrapping tick the new frame's slot 0 is presented from the inputs
  // being captured in that same edge, so the frame is coherent from its start.
  assign src_digits = wrap ? digits   : sh_digits;
  assign src_en     = wrap ? digit_en : sh_en;

`ifdef SSD_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] frame_cnt;
  logic            phase;
  logic            cnt_last;
  logic            phase_eff;
  logic [3:0]      sh_mask;
  logic [3:0]      src_mask;

  assign cnt_last  = (frame_cnt == FC_W'(BLINK_FRAMES - 1));
  // Slot 0 of a new frame already belongs to the phase that frame starts.
  assign phase_eff = wrap ? (phase ^ cnt_last) : phase;
  assign src_mask  = wrap ? blink_mask : sh_mask;
  assign blank     = phase_eff & src_mask[next_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
      sh_mask   <= 4'b0000;
    end else if (wrap) begin
      frame_cnt <= cnt_last ? '0 : frame_cnt + 1'b1;
      phase     <= phase ^ cnt_last;
      sh_mask   <= blink_mask;
    end
  end
`else
  // blink_mask has no effect in this build.
  logic unused_blink_mask;
  localparam int unused_blink_frames = BLINK_FRAMES;

  assign unused_blink_mask = ^blink_mask;
  assign blank             = 1'b0;
`endif

  assign lit = src_en[next_idx] & ~blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx             <= '0;
      sh_digits       <= 16'h0000;
      sh_en           <= 4'b0000;
      display_element <= 4'h0;
      anode_n         <= ANODE_ALL_OFF;
      frame_start     <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick) begin
        idx             <= next_idx;
        display_element <= src_digits[{next_idx, 2'b00} +: 4];
        anode_n         <= anode_for(next_idx, lit);
      end
      if (wrap) begin
        sh_digits <= digits;
        sh_en     <= digit_en;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver -- scoreboard bench for ssd_scan_driver.
// A reference model derives each cycle's expected outputs from the number of
// clock edges since reset and the per-frame input snapshot; a monitor on the
// falling edge pops and compares. Directed frames are followed by random inputs
// and random mid-slot resets.
module tb_ssd_scan_driver;

  localparam int DIV = 4;
  localparam int BF  = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic [3:0]  blink_mask;
  logic [3:0]  display_element;
  logic [3:0]  anode_n;
  logic        frame_start;

  int tests_run = 0;
  int tests_failed = 0;
  bit done = 0;

  logic [8:0] exp_q[$];
  int         n = 0;
  logic [15:0] snap_d = '0;
  logic [3:0]  snap_en = '0;
  logic [3:0]  snap_m = '0;

  ssd_scan_driver #(
    .REFRESH_DIV  (DIV),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .digits          (digits),
    .digit_en        (digit_en),
    .blink_mask      (blink_mask),
    .display_element (display_element),
    .anode_n         (anode_n),
    .frame_start     (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: slot = (edges/DIV) mod 4, frame = edges/(4*DIV).
  initial begin
    forever begin
      int slot, frame;
      logic [3:0] el, an;
      logic lit, fs;
      @(posedge clk);
      if (rst) begin
        n = 0;
        snap_d = '0; snap_en = '0; snap_m = '0;
        exp_q.push_back({4'h0, 4'hF, 1'b0});
      end else begin
        n++;
        if (n % FRAME == 0) begin
          snap_d = digits; snap_en = digit_en; snap_m = blink_mask;
        end
        slot  = (n / DIV) % 4;
        frame = n / FRAME;
        el    = 4'((snap_d >> (slot * 4)) & 16'hF);
        lit   = snap_en[slot];
`ifdef SSD_BLINK_EN
        if (((frame / BF) % 2) == 1 && snap_m[slot]) lit = 1'b0;
`endif
        an = lit ? ~(4'b0001 << slot) : 4'hF;
        fs = (n % FRAME == 0);
        exp_q.push_back({el, an, fs});
      end
    end
  end

  // Monitor: compares every presented cycle against the model.
  initial begin
    forever begin
      logic [8:0] e;
      @(negedge clk);
      if (!done && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if ({display_element, anode_n, frame_start} !== e) begin
          tests_failed++;
          $display("FAIL scoreboard t=%0t actual el=%h an=%b fs=%b required el=%h an=%b fs=%b",
                   $time, display_element, anode_n, frame_start, e[8:5], e[4:1], e[0]);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Wait until the model is one cycle into the given slot, bounded.
  task automatic wait_slot(input int s);
    int k;
    k = 0;
    while (!(((n / DIV) % 4) == s && (n % DIV) == 1) && k < 64) begin
      step();
      k++;
    end
    tests_run++;
    if (k >= 64) begin
      tests_failed++;
      $display("FAIL wait_slot%0d timeout actual n=%0d required slot=%0d", s, n, s);
    end
  endtask

  // Mid-slot reset: anodes must turn off before the next clock edge.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    tests_run++;
    if (anode_n !== 4'hF) begin
      tests_failed++;
      $display("FAIL async_reset actual anode_n=%b required anode_n=1111", anode_n);
    end
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    digits     = 16'h1A2F;
    digit_en   = 4'hF;
    blink_mask = 4'b0001;
    run(3);
    rst = 1'b0;

    // Steady display of 1A2F across several frames.
    run(4 * FRAME);

    // Mid-frame change must not appear until the next frame.
    wait_slot(2);
    digits = 16'h0000;
    run(2 * FRAME);

    // Disabled digits stay dark but still drive their nibble.
    digits   = 16'h1A2F;
    digit_en = 4'b0101;
    run(2 * FRAME);

    // Reset in the middle of slot 1.
    digit_en = 4'hF;
    run(FRAME);
    wait_slot(1);
    pulse_reset();
    run(2 * FRAME);

    // Random inputs with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        digits     = 16'($urandom);
        digit_en   = 4'($urandom);
        blink_mask = 4'($urandom);
      end
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else step();
    end

    run(2);
    done = 1'b1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
